// File: rtl/updown_target_driver_if.sv
// Request channel between a sequencer and updown_target_driver:
// a target value offered with a valid/ready handshake.
interface updown_target_driver_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_target;

    modport master (
        output req_valid,
        output req_target,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_target,
        output req_ready
    );
endinterface

// File: rtl/updown_target_driver.sv
// Steps an external up/down counter to a requested target along the shorter modular path.
// Optional shadow checker against the observed counter value: define UPDOWN_DRV_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a request; target and counter snapshot latched on accept
// CALC  | pick direction and step count from (target - snapshot) mod 2^WIDTH
// RUN   | one counter step per cycle until the remaining count hits zero
// DONE  | one-cycle completion pulse
module updown_target_driver #(
    parameter int WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    updown_target_driver_if.slave req,
    input  logic [WIDTH-1:0]      cnt_value,
    output logic                  cnt_en,
    output logic                  cnt_inst,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      step_count,
    output logic                  chk_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] diff;
    logic             diff_up;
    logic             dir;
    logic             accept;

    assign diff    = tgt - shadow;
    // An exact half-range distance is taken upward.
    assign diff_up = (diff <= HALF);
    assign accept  = (state == IDLE) && req.req_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: state_nxt = (diff == '0) ? DONE : RUN;
            RUN:  if (remaining == ONE) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req.req_ready = (state == IDLE);
        busy          = (state != IDLE);
        cnt_en        = (state == RUN);
        done          = (state == DONE);
        cnt_inst      = dir;
    end

    // dir is only rewritten when steps will follow, so cnt_inst holds across idle gaps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tgt        <= '0;
            shadow     <= '0;
            remaining  <= '0;
            dir        <= 1'b0;
            step_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt    <= req.req_target;
                        shadow <= cnt_value;
                    end
                end
                CALC: begin
                    step_count <= '0;
                    remaining  <= diff_up ? diff : (~diff + ONE);
                    if (diff != '0) begin
                        dir <= ~diff_up;
                    end
                end
                RUN: begin
                    shadow     <= dir ? (shadow - ONE) : (shadow + ONE);
                    remaining  <= remaining - ONE;
                    step_count <= step_count + ONE;
                end
                default: ;
            endcase
        end
    end

`ifdef UPDOWN_DRV_CHECK_EN
    // Shadow tracks the value the counter should show in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chk_err <= 1'b0;
        end else if (((state == RUN) || (state == DONE)) && (cnt_value != shadow)) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_updown_target_driver.sv
// Randomized bench for updown_target_driver at WIDTH=8 with a behavioural counter and
// shortest-path reference; the checker expectation follows UPDOWN_DRV_CHECK_EN.
module tb_updown_target_driver;

    localparam int W = 8;

`ifdef UPDOWN_DRV_CHECK_EN
    localparam bit CHK_BUILT = 1'b1;
`else
    localparam bit CHK_BUILT = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] cnt_value;
    logic         cnt_en;
    logic         cnt_inst;
    logic         busy;
    logic         done;
    logic [W-1:0] step_count;
    logic         chk_err;

    updown_target_driver_if #(.WIDTH(W)) req_if ();

    updown_target_driver #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req_if.slave),
        .cnt_value  (cnt_value),
        .cnt_en     (cnt_en),
        .cnt_inst   (cnt_inst),
        .busy       (busy),
        .done       (done),
        .step_count (step_count),
        .chk_err    (chk_err)
    );

    always #5 clock = ~clock;

    int           errs   = 0;
    int           checks = 0;
    logic [W-1:0] cnt_m;
    logic [W-1:0] cnt_off;
    logic         last_dir;
    logic [W-1:0] prev_steps;
    logic         chk_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; the counter model steps on the next posedge if cnt_en was high.
    task automatic step_cycle();
        logic en;
        logic inst;
        en   = cnt_en;
        inst = cnt_inst;
        @(posedge clock);
        #1;
        if (en === 1'b1) cnt_m = inst ? cnt_m - 1'b1 : cnt_m + 1'b1;
        cnt_value = cnt_m + cnt_off;
        @(negedge clock);
    endtask

    // One request from counter value v to target t; cycle k counts from the acceptance edge.
    task automatic run_request(input logic [W-1:0] v, input logic [W-1:0] t, input bit hold,
                               input int inj_k, input int abort_k);
        int           n;
        bit           up;
        logic [W-1:0] d;
        d = t - v;
        if (int'(d) <= 128) begin
            n  = int'(d);
            up = 1'b1;
        end else begin
            n  = 256 - int'(d);
            up = 1'b0;
        end
        check("ready_idle", req_if.req_ready, 1);
        cnt_m               = v;
        cnt_off             = '0;
        cnt_value           = v;
        req_if.req_target   = t;
        req_if.req_valid    = 1'b1;
        step_cycle();
        if (!hold) req_if.req_valid = 1'b0;
        for (int k = 1; k <= n + 3; k++) begin
            logic [3:0]   fexp;
            logic [W-1:0] sexp;
            if (k == abort_k) return;
            if (k - 1 == inj_k) chk_exp = 1'b1;
            if (k == 2 && n > 0) last_dir = ~up;
            fexp = {k == n + 3, k <= n + 2, (k >= 2) && (k <= n + 1), k == n + 2};
            check("flags", {req_if.req_ready, busy, cnt_en, done}, fexp);
            check("inst", cnt_inst, last_dir);
            sexp = (k == 1) ? prev_steps : ((k <= n + 1) ? W'(k - 2) : W'(n));
            check("steps", step_count, sexp);
            check("chk_err", chk_err, CHK_BUILT && chk_exp);
            if (k == n + 2) check("cnt_final", cnt_m, t);
            if (hold && k < n + 3) req_if.req_target = W'($urandom);
            cnt_off = (k + 1 == inj_k) ? W'(1) : W'(0);
            if (k < n + 3) step_cycle();
        end
        cnt_off    = '0;
        prev_steps = W'(n);
    endtask

    initial begin
        reset             = 1'b1;
        req_if.req_valid  = 1'b0;
        req_if.req_target = '0;
        cnt_value         = '0;
        cnt_m             = '0;
        cnt_off           = '0;
        last_dir          = 1'b0;
        prev_steps        = '0;
        chk_exp           = 1'b0;
        #2;
        check("rst_flags", {req_if.req_ready, busy, cnt_en, done}, 4'b1000);
        check("rst_inst", cnt_inst, 0);
        check("rst_steps", step_count, 0);
        check("rst_chk", chk_err, 0);
        @(negedge clock);
        reset = 1'b0;

        // Asynchronous reset while stepping.
        run_request(8'd10, 8'd100, 1'b0, -1, 6);
        #1 reset = 1'b1;
        #1;
        check("midrun_flags", {req_if.req_ready, busy, cnt_en, done}, 4'b1000);
        check("midrun_steps", step_count, 0);
        check("midrun_inst", cnt_inst, 0);
        req_if.req_valid = 1'b0;
        last_dir   = 1'b0;
        prev_steps = '0;
        chk_exp    = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        run_request(8'd7,   8'd7,   1'b0, -1, -1);
        run_request(8'd5,   8'd9,   1'b0, -1, -1);
        run_request(8'd250, 8'd3,   1'b0, -1, -1);
        run_request(8'd3,   8'd250, 1'b0, -1, -1);
        run_request(8'd0,   8'd128, 1'b0, -1, -1);
        run_request(8'd128, 8'd0,   1'b0, -1, -1);
        run_request(8'd0,   8'd129, 1'b0, -1, -1);

        // Held valid: second request taken only in the first IDLE cycle after done.
        run_request(8'd20, 8'd30, 1'b1, -1, -1);
        run_request(cnt_m, 8'd22, 1'b0, -1, -1);

        // Counter off by one for a single RUN cycle.
        run_request(8'd40, 8'd50, 1'b0, 4, -1);
        run_request(8'd200, 8'd190, 1'b0, -1, -1);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] v;
            logic [W-1:0] t;
            v = W'($urandom);
            if (i % 3 == 0) t = v + W'($urandom_range(126, 130));
            else            t = W'($urandom);
            run_request(v, t, 1'($urandom_range(0, 1)), -1, -1);
        end
        req_if.req_valid = 1'b0;
        step_cycle();
        check("end_idle", {req_if.req_ready, busy, cnt_en, done}, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/updown_target_driver.md
# updown_target_driver

Command-side companion to the up/down counter: accepts a target value over a valid/ready request, then drives the counter's step-enable and direction (`inst`) lines cycle by cycle until the counter reaches the target, choosing the shorter path modulo 2^WIDTH. It sits between a test or control sequencer and the counter. It keeps a shadow of the expected counter value and, optionally, checks the observed counter value against that shadow.

## Interface
- `WIDTH`, 32, counter and target width in bits.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: target request present.
- `req_ready` out 1: driver idle and able to accept.
- `req_target` in WIDTH: requested final counter value.
- `cnt_value` in WIDTH: current counter output.
- `cnt_en` out 1: counter steps on the next clock edge when high. The counter holds when low.
- `cnt_inst` out 1: direction to the counter, 0 = up, 1 = down.
- `busy` out 1: request accepted and not yet completed.
- `done` out 1: one-cycle pulse when the target is reached.
- `step_count` out WIDTH: steps issued for the current or last request.
- `chk_err` out 1: sticky shadow mismatch flag. Present only with the configuration macro, tied 0 otherwise.

## Operation
- States: IDLE, CALC, RUN, DONE.
- IDLE:
  - `req_ready`=1.
  - When `req_valid`&&`req_ready`, latch `req_target` into `tgt` and `cnt_value` into `shadow`, then go to CALC.
- CALC (one cycle):
  - diff = (`tgt` − `shadow`) mod 2^WIDTH.
  - diff=0: go to DONE with remaining=0.
  - diff ≤ 2^(WIDTH−1): dir=up, remaining=diff. An exact half-range tie resolves to up.
  - Otherwise: dir=down, remaining=2^WIDTH − diff.
  - Clear `step_count`.
- RUN:
  - Drive `cnt_en`=1 and `cnt_inst`=dir every cycle.
  - Each edge: `shadow` ±1 (wrapping), remaining −1, `step_count` +1.
  - Go to DONE on the edge where remaining goes 1→0.
- DONE: `done`=1 for exactly one cycle, `cnt_en`=0, then return to IDLE.
- `busy`=1 in CALC, RUN and DONE.
- `req_ready`=0 outside IDLE. `req_valid` in those states is ignored and not queued.
- `cnt_inst` holds its last value when `cnt_en`=0. Its reset value is 0.
- All arithmetic is unsigned, modulo 2^WIDTH. Wrap-around through 0 and through 2^WIDTH−1 is legal and expected.
- `cnt_value` is sampled only at acceptance and, when the checker is compiled in, during checking. The driver never waits on the counter.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - `req_ready`=1.
  - `cnt_en`, `cnt_inst`, `busy`, `done` = 0.
  - `step_count`=0 and `chk_err`=0.
  - Reset during RUN stops stepping in the same cycle. No `done` is issued.
- Acceptance edge E0 → CALC in cycle 1 → RUN in cycles 2..N+1 → `done` in cycle N+2 → `req_ready`=1 in cycle N+3.
- When N=0, `done` is high in cycle 2 and `cnt_en` is never asserted.
- The counter is assumed to update on the same edge that samples `cnt_en`=1, so its new value is visible the next cycle.
- The earliest back-to-back request is accepted in the first IDLE cycle after DONE.

## Configuration
- `UPDOWN_DRV_CHECK_EN` defined:
  - In every RUN and DONE cycle, compare `cnt_value` with `shadow`.
  - On a mismatch, set `chk_err`=1 at the next edge. It stays set until reset.
  - Operation is otherwise unaffected and stepping continues.
- `UPDOWN_DRV_CHECK_EN` undefined: no comparator is built and `chk_err` is constant 0.

## Test plan
- Reset / zero-step:
  - Assert `reset` mid-RUN → the same cycle `cnt_en`=0, `busy`=0, `req_ready`=1, `step_count`=0.
  - Then request target=7 with `cnt_value`=7 → `done` in cycle 2 after acceptance, `cnt_en` never high, `step_count`=0.
- Simple up: WIDTH=8, `cnt_value`=5, target=9 → 4 cycles of `cnt_en`=1, `cnt_inst`=0. `done` in cycle 6, `step_count`=4, counter reads 9.
- Wrap up: WIDTH=8, `cnt_value`=250, target=3 → 9 up-steps through 255→0, `step_count`=9.
- Wrap down: WIDTH=8, `cnt_value`=3, target=250 → 9 down-steps.
- Half-range tie: WIDTH=8, `cnt_value`=0, target=128 → 128 up-steps.
- Back-to-back and checker:
  - Hold `req_valid` high through a request → the second request is accepted only in the IDLE cycle after `done`.
  - With `UPDOWN_DRV_CHECK_EN` defined, force `cnt_value` off by 1 in RUN → `chk_err`=1 on the next edge and it stays 1 after `done`.
